// File: rtl/kalman_sequencer.sv
// Kalman phase sequencer: one go pulse per phase, waits on done; N-iteration/continuous runs, predict-only skip, watchdog, abort.
// All outputs registered (state change visible 1 cycle after the deciding edge); engines pace it via done pulses, no backpressure.
module kalman_sequencer #(
  parameter int ITER_W    = 8,
  parameter int TIMEOUT_W = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 i_start,
  input  logic                 i_abort,
  input  logic                 i_continuous,
  input  logic [ITER_W-1:0]    i_num_iter,
  input  logic [TIMEOUT_W-1:0] i_timeout_limit,
  input  logic                 i_meas_valid,
  input  logic                 i_mul_state_done,
  input  logic                 i_mul_cov_done,
  input  logic                 i_inv_done,
  input  logic                 i_mul_gain_done,
  input  logic                 i_add_state_done,
  input  logic                 i_mul_cov_update_done,
  output logic [2:0]           o_state,
  output logic                 o_go_mul_state,
  output logic                 o_go_mul_cov,
  output logic                 o_go_gain,
  output logic                 o_go_add_state,
  output logic                 o_go_cov_update,
  output logic                 o_busy,
  output logic                 o_iter_done,
  output logic                 o_error,
  output logic [2:0]           o_err_phase,
  output logic [ITER_W-1:0]    o_iter_count
);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PRED_STATE = 3'd1,
    S_PRED_COV   = 3'd2,
    S_GAIN       = 3'd3,
    S_UPD_STATE  = 3'd4,
    S_UPD_COV    = 3'd5,
    S_DONE       = 3'd6,
    S_ERROR      = 3'd7
  } state_t;

  state_t                r_state;
  state_t                w_next;
  logic                  r_entry;
  logic [TIMEOUT_W-1:0]  r_wdog;
  logic                  r_inv_seen;
  logic                  r_gain_seen;
  logic                  r_cont;
  logic [ITER_W-1:0]     r_num_iter;
  logic [TIMEOUT_W-1:0]  r_timeout;
  logic                  r_go_mul_state;
  logic                  r_go_mul_cov;
  logic                  r_go_gain;
  logic                  r_go_add_state;
  logic                  r_go_cov_update;
  logic                  r_busy;
  logic                  r_iter_done;
  logic                  r_error;
  logic [2:0]            r_err_phase;
  logic [ITER_W-1:0]     r_iter_count;

  logic w_in_phase;
  logic w_start_ok;
  logic w_inv;
  logic w_gmul;
  logic w_gain_both;
  logic w_phase_done;
  logic w_expire;
  logic w_more;

  // Done pulses are masked during the go cycle (r_entry) so a stale pulse cannot end a fresh phase.
  assign w_in_phase  = (r_state != S_IDLE) && (r_state != S_DONE) && (r_state != S_ERROR);
  assign w_start_ok  = i_start && !i_abort && ((r_state == S_IDLE) || (r_state == S_ERROR));
  assign w_inv       = i_inv_done && !r_entry;
  assign w_gmul      = i_mul_gain_done && !r_entry;
  assign w_gain_both = (r_inv_seen || w_inv) && (r_gain_seen || w_gmul);

  always_comb begin
    w_phase_done = 1'b0;
    case (r_state)
      S_PRED_STATE: w_phase_done = i_mul_state_done && !r_entry;
      S_PRED_COV:   w_phase_done = i_mul_cov_done && !r_entry;
      S_GAIN:       w_phase_done = w_gain_both;
      S_UPD_STATE:  w_phase_done = i_add_state_done && !r_entry;
      S_UPD_COV:    w_phase_done = i_mul_cov_update_done && !r_entry;
      default:      w_phase_done = 1'b0;
    endcase
  end

  // r_wdog counts cycles spent in the phase including the current one, so a phase lasts at most r_timeout cycles.
  assign w_expire = w_in_phase && (r_timeout != '0) && (r_wdog == r_timeout) && !w_phase_done;
  // r_iter_count has already been bumped on DONE entry.
  assign w_more   = r_cont && ((r_num_iter == '0) || (r_iter_count < r_num_iter));

  always_comb begin
    w_next = r_state;
    if (i_abort) begin
      w_next = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE, S_ERROR: if (i_start) w_next = S_PRED_STATE;
        S_PRED_STATE:    if (w_expire) w_next = S_ERROR; else if (w_phase_done) w_next = S_PRED_COV;
        S_PRED_COV:      if (w_expire) w_next = S_ERROR;
                         else if (w_phase_done) w_next = i_meas_valid ? S_GAIN : S_DONE;
        S_GAIN:          if (w_expire) w_next = S_ERROR; else if (w_phase_done) w_next = S_UPD_STATE;
        S_UPD_STATE:     if (w_expire) w_next = S_ERROR; else if (w_phase_done) w_next = S_UPD_COV;
        S_UPD_COV:       if (w_expire) w_next = S_ERROR; else if (w_phase_done) w_next = S_DONE;
        S_DONE:          w_next = w_more ? S_PRED_STATE : S_IDLE;
        default:         w_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state         <= S_IDLE;
      r_entry         <= 1'b0;
      r_wdog          <= '0;
      r_inv_seen      <= 1'b0;
      r_gain_seen     <= 1'b0;
      r_cont          <= 1'b0;
      r_num_iter      <= '0;
      r_timeout       <= '0;
      r_go_mul_state  <= 1'b0;
      r_go_mul_cov    <= 1'b0;
      r_go_gain       <= 1'b0;
      r_go_add_state  <= 1'b0;
      r_go_cov_update <= 1'b0;
      r_busy          <= 1'b0;
      r_iter_done     <= 1'b0;
      r_error         <= 1'b0;
      r_err_phase     <= 3'd0;
      r_iter_count    <= '0;
    end else begin
      r_state         <= w_next;
      r_entry         <= (w_next != r_state);
      r_go_mul_state  <= (w_next == S_PRED_STATE) && (r_state != S_PRED_STATE);
      r_go_mul_cov    <= (w_next == S_PRED_COV)   && (r_state != S_PRED_COV);
      r_go_gain       <= (w_next == S_GAIN)       && (r_state != S_GAIN);
      r_go_add_state  <= (w_next == S_UPD_STATE)  && (r_state != S_UPD_STATE);
      r_go_cov_update <= (w_next == S_UPD_COV)    && (r_state != S_UPD_COV);
      r_busy          <= (w_next != S_IDLE) && (w_next != S_ERROR);
      r_iter_done     <= (w_next == S_DONE);

      if (w_next != r_state)
        r_wdog <= TIMEOUT_W'(1);
      else if (w_in_phase)
        r_wdog <= r_wdog + TIMEOUT_W'(1);

      if ((w_next == S_GAIN) && (r_state != S_GAIN)) begin
        r_inv_seen  <= 1'b0;
        r_gain_seen <= 1'b0;
      end else if (r_state == S_GAIN) begin
        r_inv_seen  <= r_inv_seen || w_inv;
        r_gain_seen <= r_gain_seen || w_gmul;
      end

      if (i_abort) begin
        r_iter_count <= '0;
        r_error      <= 1'b0;
        r_err_phase  <= 3'd0;
      end else if (w_start_ok) begin
        r_cont       <= i_continuous;
        r_num_iter   <= i_num_iter;
        r_timeout    <= i_timeout_limit;
        r_iter_count <= '0;
        r_error      <= 1'b0;
        r_err_phase  <= 3'd0;
      end else begin
        if (w_next == S_DONE)
          r_iter_count <= r_iter_count + ITER_W'(1);
        if (w_expire) begin
          r_error     <= 1'b1;
          r_err_phase <= r_state;
        end
      end
    end
  end

  assign o_state         = r_state;
  assign o_go_mul_state  = r_go_mul_state;
  assign o_go_mul_cov    = r_go_mul_cov;
  assign o_go_gain       = r_go_gain;
  assign o_go_add_state  = r_go_add_state;
  assign o_go_cov_update = r_go_cov_update;
  assign o_busy          = r_busy;
  assign o_iter_done     = r_iter_done;
  assign o_error         = r_error;
  assign o_err_phase     = r_err_phase;
  assign o_iter_count    = r_iter_count;

endmodule

// File: tb/tb_kalman_sequencer.sv
// Directed bench for kalman_sequencer: linear steps, immediate assertions against hand-computed values.
module tb_kalman_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        i_start = 0, i_abort = 0, i_continuous = 0, i_meas_valid = 0;
  logic [7:0]  i_num_iter = 0;
  logic [15:0] i_timeout_limit = 0;
  logic        i_mul_state_done = 0, i_mul_cov_done = 0, i_inv_done = 0, i_mul_gain_done = 0;
  logic        i_add_state_done = 0, i_mul_cov_update_done = 0;
  logic [2:0]  o_state, o_err_phase;
  logic        o_go_mul_state, o_go_mul_cov, o_go_gain, o_go_add_state, o_go_cov_update;
  logic        o_busy, o_iter_done, o_error;
  logic [7:0]  o_iter_count;

  int n_assert = 0;
  int n_fail   = 0;
  int c_ms = 0, c_mc = 0, c_g = 0, c_as = 0, c_cu = 0, c_id = 0;
  int s_ms, s_mc, s_g, s_as, s_cu, s_id;

  always #5 clk = ~clk;

  kalman_sequencer #(.ITER_W(8), .TIMEOUT_W(16)) dut (
    .clk(clk), .reset(reset),
    .i_start(i_start), .i_abort(i_abort), .i_continuous(i_continuous),
    .i_num_iter(i_num_iter), .i_timeout_limit(i_timeout_limit), .i_meas_valid(i_meas_valid),
    .i_mul_state_done(i_mul_state_done), .i_mul_cov_done(i_mul_cov_done),
    .i_inv_done(i_inv_done), .i_mul_gain_done(i_mul_gain_done),
    .i_add_state_done(i_add_state_done), .i_mul_cov_update_done(i_mul_cov_update_done),
    .o_state(o_state), .o_go_mul_state(o_go_mul_state), .o_go_mul_cov(o_go_mul_cov),
    .o_go_gain(o_go_gain), .o_go_add_state(o_go_add_state), .o_go_cov_update(o_go_cov_update),
    .o_busy(o_busy), .o_iter_done(o_iter_done), .o_error(o_error),
    .o_err_phase(o_err_phase), .o_iter_count(o_iter_count)
  );

  always @(posedge clk) begin
    if (o_go_mul_state)  c_ms++;
    if (o_go_mul_cov)    c_mc++;
    if (o_go_gain)       c_g++;
    if (o_go_add_state)  c_as++;
    if (o_go_cov_update) c_cu++;
    if (o_iter_done)     c_id++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic go_of(input logic [2:0] ph);
    case (ph)
      3'd1:    return o_go_mul_state;
      3'd2:    return o_go_mul_cov;
      3'd3:    return o_go_gain;
      3'd4:    return o_go_add_state;
      3'd5:    return o_go_cov_update;
      default: return 1'b0;
    endcase
  endfunction

  task automatic snap();
    s_ms = c_ms; s_mc = c_mc; s_g = c_g; s_as = c_as; s_cu = c_cu; s_id = c_id;
  endtask

  task automatic pulse_done(input logic [2:0] ph);
    case (ph)
      3'd1: i_mul_state_done = 1;
      3'd2: i_mul_cov_done = 1;
      3'd3: begin i_inv_done = 1; i_mul_gain_done = 1; end
      3'd4: i_add_state_done = 1;
      3'd5: i_mul_cov_update_done = 1;
      default: ;
    endcase
    tick();
    i_mul_state_done = 0; i_mul_cov_done = 0; i_inv_done = 0; i_mul_gain_done = 0;
    i_add_state_done = 0; i_mul_cov_update_done = 0;
  endtask

  // Entered on the go cycle; done arrives 3 cycles after go; returns on the first cycle of the next state.
  task automatic do_phase(input logic [2:0] ph);
    check($sformatf("ph%0d state", ph), o_state, ph);
    check($sformatf("ph%0d go", ph), go_of(ph), 1);
    tick();
    check($sformatf("ph%0d go 1cyc", ph), go_of(ph), 0);
    tick(2);
    pulse_done(ph);
  endtask

  task automatic start_run();
    i_start = 1;
    tick();
    i_start = 0;
  endtask

  initial begin
    // reset state
    tick(2);
    check("rst state", o_state, 0);
    check("rst busy", o_busy, 0);
    check("rst error", o_error, 0);
    check("rst iter_count", o_iter_count, 0);
    check("rst gos", {o_go_mul_state, o_go_mul_cov, o_go_gain, o_go_add_state, o_go_cov_update, o_iter_done}, 0);
    reset = 0;
    tick(2);
    check("idle after rst", o_state, 0);

    // single shot with measurement; gain dones same cycle
    i_meas_valid = 1; snap();
    start_run();
    check("t1 busy", o_busy, 1);
    for (int p = 1; p <= 5; p++) do_phase(3'(p));
    check("t1 DONE", o_state, 6);
    check("t1 iter_done", o_iter_done, 1);
    check("t1 iter_count", o_iter_count, 1);
    tick();
    check("t1 back idle", o_state, 0);
    check("t1 busy off", o_busy, 0);
    check("t1 iter_done off", o_iter_done, 0);
    check("t1 go counts", {8'(c_ms-s_ms), 8'(c_mc-s_mc), 8'(c_g-s_g), 8'(c_as-s_as)}, 32'h01010101);
    check("t1 cu/id counts", {8'(c_cu-s_cu), 8'(c_id-s_id)}, 16'h0101);

    // predict-only
    i_meas_valid = 0; snap();
    start_run();
    do_phase(1);
    do_phase(2);
    check("t2 skip to DONE", o_state, 6);
    check("t2 iter_count", o_iter_count, 1);
    tick();
    check("t2 idle", o_state, 0);
    check("t2 no update gos", {8'(c_g-s_g), 8'(c_as-s_as), 8'(c_cu-s_cu)}, 0);

    // done in go cycle ignored; staggered gain dones
    i_meas_valid = 1; snap();
    start_run();
    check("t3 go cycle", o_go_mul_state, 1);
    pulse_done(1);
    check("t3 done in go ignored", o_state, 1);
    pulse_done(1);
    do_phase(2);
    check("t3 gain entry", o_state, 3);
    tick();
    i_mul_gain_done = 1; tick(); i_mul_gain_done = 0;
    tick(4);
    check("t3 wait inv", o_state, 3);
    i_inv_done = 1; tick(); i_inv_done = 0;
    check("t3 left gain", o_state, 4);
    check("t3 go_add_state", o_go_add_state, 1);
    tick(3);
    pulse_done(4);
    do_phase(5);
    check("t3 DONE", o_state, 6);
    tick();

    // continuous, 3 iterations; mid-run config changes must not matter
    i_meas_valid = 0; i_continuous = 1; i_num_iter = 3; snap();
    start_run();
    i_continuous = 0; i_num_iter = 1;
    for (int i = 0; i < 3; i++) begin
      do_phase(1);
      do_phase(2);
      check("t4 DONE", o_state, 6);
      check("t4 iter_count", o_iter_count, i + 1);
      tick();
      check("t4 next", o_state, (i < 2) ? 1 : 0);
    end
    check("t4 iter_done count", c_id - s_id, 3);
    check("t4 final count", o_iter_count, 3);

    // unbounded until abort
    i_continuous = 1; i_num_iter = 0;
    start_run();
    for (int i = 0; i < 4; i++) begin
      do_phase(1);
      do_phase(2);
      tick();
    end
    check("t4u still running", o_state, 1);
    check("t4u count", o_iter_count, 4);
    i_abort = 1; tick(); i_abort = 0;
    check("t4u abort idle", o_state, 0);
    check("t4u abort count", o_iter_count, 0);
    check("t4u abort busy", o_busy, 0);

    // watchdog in UPD_STATE
    i_continuous = 0; i_meas_valid = 1; i_timeout_limit = 10;
    start_run();
    do_phase(1); do_phase(2); do_phase(3);
    check("t5 upd entry", o_state, 4);
    tick(9);
    check("t5 last phase cycle", o_state, 4);
    tick();
    check("t5 ERROR", o_state, 7);
    check("t5 error", o_error, 1);
    check("t5 err_phase", o_err_phase, 4);
    check("t5 busy", o_busy, 0);
    tick(3);
    check("t5 holds", {o_state, o_error, o_go_mul_state, o_go_add_state}, {3'd7, 1'b1, 1'b0, 1'b0});
    start_run();
    check("t5 restart", o_state, 1);
    check("t5 error cleared", {o_error, o_err_phase}, 0);
    tick(9);
    i_mul_state_done = 1; tick(); i_mul_state_done = 0;
    check("t5 done wins expiry", o_state, 2);
    i_abort = 1; tick(); i_abort = 0;
    check("t5 abort idle", o_state, 0);

    // abort in GAIN with inv_done same cycle
    i_timeout_limit = 0; snap();
    start_run();
    do_phase(1); do_phase(2);
    check("t6 gain", o_state, 3);
    tick();
    i_mul_gain_done = 1; tick(); i_mul_gain_done = 0;
    i_abort = 1; i_inv_done = 1; tick(); i_abort = 0; i_inv_done = 0;
    check("t6 abort idle", o_state, 0);
    check("t6 no go_add", o_go_add_state, 0);
    tick(2);
    check("t6 no go_add count", c_as - s_as, 0);

    // reset mid-UPD_COV
    i_continuous = 1; i_num_iter = 0;
    start_run();
    for (int p = 1; p <= 5; p++) do_phase(3'(p));
    tick();
    check("t6 2nd iter", {o_state, o_iter_count}, {3'd1, 8'd1});
    for (int p = 1; p <= 4; p++) do_phase(3'(p));
    #3 reset = 1;
    #1;
    check("t6 rst state", o_state, 0);
    check("t6 rst outs", {o_busy, o_iter_done, o_error, o_err_phase, o_iter_count}, 0);
    check("t6 rst go", o_go_cov_update, 0);
    tick();
    reset = 0;
    tick(3);
    check("t6 stays idle", {o_state, o_busy}, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
